// File: rtl/logic_acc_stage.sv
// ============================================================================
// logic_acc_stage : result select, accumulator and flagged output FIFO for the
//                   8-bit bitwise logic unit.   Rev 1.0
// ============================================================================
`default_nettype none

module logic_acc_stage #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [WIDTH-1:0]           in_xor_r,
  input  logic [WIDTH-1:0]           in_or_r,
  input  logic [WIDTH-1:0]           in_and_r,
  input  logic [WIDTH-1:0]           in_b,
  output logic [WIDTH-1:0]           acc_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       out_parity,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 2;

  localparam logic [1:0] OP_XOR  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic [WIDTH-1:0] acc_q;
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q, count_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    head;
  logic [WIDTH-1:0] sel;
  logic             accept, pop;

  always_comb begin
    sel = in_b;
    case (in_op)
      OP_XOR:  sel = in_xor_r;
      OP_OR:   sel = in_or_r;
      OP_AND:  sel = in_and_r;
      OP_LOAD: sel = in_b;
      default: sel = in_b;
    endcase
  end

  // Full/empty come only from the occupancy count; pointers just wrap.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign head       = mem_q[rd_q];
  assign out_data   = out_valid ? head[EW-1:2] : '0;
  assign out_zero   = out_valid ? head[1]      : 1'b0;
  assign out_parity = out_valid ? head[0]      : 1'b0;
  assign acc_out    = acc_q;
  assign count      = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= ACC_RESET;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        mem_q[wr_q] <= {sel, (sel == '0), ^sel};
        acc_q       <= sel;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_logic_acc_stage.sv
// ============================================================================
// tb_logic_acc_stage : directed and scoreboard bench for logic_acc_stage
//                      (DEPTH=2 and DEPTH=4 instances).   Rev 1.0
// ============================================================================
`default_nettype none

module tb_logic_acc_stage;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   in_op = 2'b00;
  logic [W-1:0] in_b = '0;
  logic         out_ready = 1'b0;

  logic [W-1:0] acc2, data2, acc4, data4;
  logic         rdy2, vld2, z2, p2, rdy4, vld4, z4, p4;
  logic [1:0]   cnt2;
  logic [2:0]   cnt4;

  // The logic circuits upstream: operand A is each stage's own accumulator.
  wire [W-1:0] xor2 = acc2 ^ in_b;
  wire [W-1:0] or2  = acc2 | in_b;
  wire [W-1:0] and2 = acc2 & in_b;
  wire [W-1:0] xor4 = acc4 ^ in_b;
  wire [W-1:0] or4  = acc4 | in_b;
  wire [W-1:0] and4 = acc4 & in_b;

  // {in_ready, out_valid, count, out_data, out_zero, out_parity, acc_out}
  wire [21:0] st2 = {rdy2, vld2, cnt2, data2, z2, p2, acc2};
  wire [22:0] st4 = {rdy4, vld4, cnt4, data4, z4, p4, acc4};

  logic_acc_stage #(.WIDTH(W), .DEPTH(2), .ACC_RESET(8'h00)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_op(in_op),
    .in_xor_r(xor2), .in_or_r(or2), .in_and_r(and2), .in_b(in_b), .acc_out(acc2),
    .out_valid(vld2), .out_ready(out_ready), .out_data(data2), .out_zero(z2),
    .out_parity(p2), .count(cnt2)
  );

  logic_acc_stage #(.WIDTH(W), .DEPTH(4), .ACC_RESET(8'h00)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_op(in_op),
    .in_xor_r(xor4), .in_or_r(or4), .in_and_r(and4), .in_b(in_b), .acc_out(acc4),
    .out_valid(vld4), .out_ready(out_ready), .out_data(data4), .out_zero(z4),
    .out_parity(p4), .count(cnt4)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    e = {1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL reset_hold: got %h exp %h", st2, e); end
    rst_n = 1'b1;
    in_valid = 1'b1; in_op = 2'b11; in_b = 8'h5A;
    tick();
    @(negedge clk);
    in_op = 2'b00; in_b = 8'hFF;
    tick();
    in_valid = 1'b0;
    e = {1'b0, 1'b1, 2'd2, 8'h5A, 1'b0, 1'b0, 8'hA5};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL reset_prefill: got %h exp %h", st2, e); end
    #2 rst_n = 1'b0;
    #1;
    e = {1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL reset_flush: got %h exp %h", st2, e); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_chain();
    logic [1:0] ops [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
    logic [7:0] bs  [4] = '{8'h5A, 8'hFF, 8'h00, 8'h07};
    logic [7:0] rs  [4] = '{8'h5A, 8'hA5, 8'h00, 8'h07};
    logic       zs  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       ps  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [21:0] e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_op = ops[i]; in_b = bs[i];
      tick();
      e = {1'b1, 1'b1, 2'd1, rs[i], zs[i], ps[i], rs[i]};
      vec++;
      if (st2 !== e) begin errs++; $display("FAIL chain[%0d]: got %h exp %h", i, st2, e); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    e = {1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h07};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL chain_drain: got %h exp %h", st2, e); end
  endtask

  task automatic test_backpressure();
    logic [21:0] e;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b11; in_b = 8'h11;
    tick();
    e = {1'b1, 1'b1, 2'd1, 8'h11, 1'b0, 1'b0, 8'h11};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL bp_first: got %h exp %h", st2, e); end
    @(negedge clk);
    in_op = 2'b00; in_b = 8'h0F;
    tick();
    e = {1'b0, 1'b1, 2'd2, 8'h11, 1'b0, 1'b0, 8'h1E};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL bp_full: got %h exp %h", st2, e); end
    @(negedge clk);
    in_op = 2'b01; in_b = 8'hF0;
    tick();
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL bp_held: got %h exp %h", st2, e); end
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    e = {1'b1, 1'b1, 2'd1, 8'h1E, 1'b0, 1'b0, 8'h1E};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL bp_pop_only: got %h exp %h", st2, e); end
    tick();
    e = {1'b1, 1'b1, 2'd1, 8'hFE, 1'b0, 1'b1, 8'hFE};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL bp_third: got %h exp %h", st2, e); end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    e = {1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'hFE};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL bp_drain: got %h exp %h", st2, e); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b11; in_b = 8'h3C;
    tick();
    e = {1'b1, 1'b1, 2'd1, 8'h3C, 1'b0, 1'b0, 8'h3C};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL simul_setup: got %h exp %h", st2, e); end
    @(negedge clk);
    out_ready = 1'b1; in_op = 2'b10; in_b = 8'h0F;
    tick();
    e = {1'b1, 1'b1, 2'd1, 8'h0C, 1'b0, 1'b0, 8'h0C};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL simul_both: got %h exp %h", st2, e); end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    e = {1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h0C};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL simul_drain: got %h exp %h", st2, e); end
  endtask

  task automatic test_wrap();
    logic [9:0]  q2 [$];
    logic [9:0]  q4 [$];
    logic [7:0]  m2, m4, s2, s4, d2, d4;
    logic [21:0] e2;
    logic [22:0] e4;
    logic        a2, a4, pp2, pp4;
    m2 = 8'h00; m4 = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 44) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_op     = 2'($urandom_range(0, 3));
        in_b      = 8'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      d2 = (q2.size() != 0) ? q2[0][9:2] : 8'h00;
      d4 = (q4.size() != 0) ? q4[0][9:2] : 8'h00;
      e2 = {(q2.size() < 2), (q2.size() != 0), 2'(q2.size()), d2,
            (q2.size() != 0) ? q2[0][1:0] : 2'b00, m2};
      e4 = {(q4.size() < 4), (q4.size() != 0), 3'(q4.size()), d4,
            (q4.size() != 0) ? q4[0][1:0] : 2'b00, m4};
      vec++;
      if (st2 !== e2) begin errs++; $display("FAIL wrap_d2[%0d]: got %h exp %h", i, st2, e2); end
      vec++;
      if (st4 !== e4) begin errs++; $display("FAIL wrap_d4[%0d]: got %h exp %h", i, st4, e4); end
      case (in_op)
        2'b00:   begin s2 = m2 ^ in_b; s4 = m4 ^ in_b; end
        2'b01:   begin s2 = m2 | in_b; s4 = m4 | in_b; end
        2'b10:   begin s2 = m2 & in_b; s4 = m4 & in_b; end
        default: begin s2 = in_b;      s4 = in_b;      end
      endcase
      a2  = in_valid && (q2.size() < 2);
      a4  = in_valid && (q4.size() < 4);
      pp2 = (q2.size() != 0) && out_ready;
      pp4 = (q4.size() != 0) && out_ready;
      tick();
      if (pp2) void'(q2.pop_front());
      if (pp4) void'(q4.pop_front());
      if (a2) begin q2.push_back({s2, (s2 == 8'h00), ^s2}); m2 = s2; end
      if (a4) begin q4.push_back({s4, (s4 == 8'h00), ^s4}); m4 = s4; end
    end
  endtask

  task automatic test_async_reset();
    logic [21:0] e;
    logic [22:0] e4;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b11; in_b = 8'h99;
    tick();
    in_valid = 1'b0;
    e = {1'b1, 1'b1, 2'd1, 8'h99, 1'b0, 1'b0, 8'h99};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL async_setup: got %h exp %h", st2, e); end
    #2 rst_n = 1'b0;
    #1;
    e  = {1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    e4 = {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL async_clear_d2: got %h exp %h", st2, e); end
    vec++;
    if (st4 !== e4) begin errs++; $display("FAIL async_clear_d4: got %h exp %h", st4, e4); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_op = 2'b11; in_b = 8'h5A;
    tick();
    in_valid = 1'b0;
    e = {1'b1, 1'b1, 2'd1, 8'h5A, 1'b0, 1'b0, 8'h5A};
    vec++;
    if (st2 !== e) begin errs++; $display("FAIL async_first_op: got %h exp %h", st2, e); end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
